// File: rtl/button_event_scanner.sv
// Push-button / slide-switch front-end: 2-FF sync, per-input debounce, press pulses,
// and a 4-entry first-word fall-through event FIFO tagged with the slide setting.
module button_event_scanner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic [3:0] slide,
  output logic [3:0] button_level,
  output logic [3:0] slide_level,
  output logic [3:0] press_pulse,
  output logic       event_valid,
  output logic [5:0] event_code,
  input  logic       event_ready,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       raw;
  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [3:0]       prev_q;
  logic [3:0]       rise;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       push_sel;
  logic [1:0]       push_idx;
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q, count_d;
  logic [5:0]       mem_q [4];
  logic             push, pop;
  logic             ovf_q, ovf_d;

  // Bits [3:0] are buttons, [7:4] slides; all eight share the same debounce rule.
  assign raw = {slide, button};

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q[3:0];
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise = level_d[3:0] & ~level_q[3:0];

  // Lowest-index pending button wins the single push slot.
  always_comb begin
    push_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) begin
        push_idx = 2'(i);
      end
    end
  end

  assign pop      = event_valid && event_ready;
  assign push     = (pend_q != 4'd0) && ((count_q != 3'd4) || pop);
  assign push_sel = push ? (4'b0001 << push_idx) : 4'b0000;
  assign pend_d   = (pend_q & ~push_sel) | rise;
  // A rise on a still-pending button (not drained this edge) is merged and lost.
  assign ovf_d    = ovf_q | ((rise & pend_q & ~push_sel) != 4'd0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {level_q[7:4], push_idx};
    end
  end

  assign button_level = level_q[3:0];
  assign slide_level  = level_q[7:4];
  assign press_pulse  = level_q[3:0] & ~prev_q;
  assign event_valid  = (count_q != 3'd0);
  // Storage is not reset, so the head is masked while the queue is empty.
  assign event_code   = event_valid ? mem_q[rd_ptr_q] : 6'd0;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_button_event_scanner.sv
// Bench for button_event_scanner: directed table/sequences plus random stimulus
// compared every cycle against a window-based behavioural model.
module tb_button_event_scanner;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic [3:0] button, slide;
  logic [3:0] button_level, slide_level, press_pulse;
  logic       event_valid;
  logic [5:0] event_code;
  logic       ready;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  button_event_scanner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock        (clk),
    .reset        (reset),
    .button       (button),
    .slide        (slide),
    .button_level (button_level),
    .slide_level  (slide_level),
    .press_pulse  (press_pulse),
    .event_valid  (event_valid),
    .event_code   (event_code),
    .event_ready  (ready),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [7:0] rawhist [$];
  logic [7:0] exhist  [$];
  logic [7:0] m_level;
  logic [3:0] m_pulse;
  logic [3:0] m_pend;
  logic [5:0] m_fifo  [$];
  logic       m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level of an input follows a new value once the last D synchronized samples all differ from it.
  task automatic model_step();
    logic [7:0] ex, nl;
    logic [3:0] rise, pb;
    bit         pop, psh, all;
    int         idx;
    if (reset) begin
      rawhist.delete();
      rawhist.push_back(8'h00);
      rawhist.push_back(8'h00);
      exhist.delete();
      m_fifo.delete();
      m_level = '0;
      m_pulse = '0;
      m_pend  = '0;
      m_ovf   = 1'b0;
      return;
    end
    ex = rawhist[rawhist.size()-2];
    rawhist.push_back({slide, button});
    if (rawhist.size() > 4) void'(rawhist.pop_front());
    exhist.push_back(ex);
    if (exhist.size() > D) void'(exhist.pop_front());
    nl = m_level;
    if (exhist.size() == D) begin
      for (int b = 0; b < 8; b++) begin
        all = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (exhist[j][b] == m_level[b]) all = 1'b0;
        end
        if (all) nl[b] = ~m_level[b];
      end
    end
    rise = nl[3:0] & ~m_level[3:0];
    pb   = m_pend;
    pop  = (m_fifo.size() > 0) && ready;
    psh  = (pb != 4'd0) && ((m_fifo.size() < 4) || pop);
    idx  = 0;
    for (int i = 3; i >= 0; i--) begin
      if (pb[i]) idx = i;
    end
    if (pop) void'(m_fifo.pop_front());
    if (psh) begin
      m_fifo.push_back({m_level[7:4], 2'(idx)});
      m_pend[idx] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        if (pb[i] && !(psh && idx == i)) m_ovf = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    m_pulse = rise;
    m_level = nl;
  endtask

  task automatic tick();
    logic [31:0] dv, ev;
    logic        mv;
    logic [5:0]  mc;
    @(posedge clk);
    model_step();
    #1;
    mv = (m_fifo.size() > 0);
    mc = mv ? m_fifo[0] : 6'd0;
    dv = {12'd0, button_level, slide_level, press_pulse, event_valid, event_code, overflow};
    ev = {12'd0, m_level[3:0], m_level[7:4], m_pulse, mv, mc, m_ovf};
    chk("model", dv, ev);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    button = 4'h0;
    slide  = 4'h0;
    ready  = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  typedef struct {
    logic [3:0] b;
    logic [3:0] s;
    logic       r;
    logic [3:0] bl;
    logic [3:0] sl;
    logic [3:0] p;
    logic       v;
    logic [5:0] c;
  } vec_t;

  vec_t tbl [16];
  int   exp_idx [5];
  int   pct;
  int   bi;

  initial begin
    reset  = 1'b1;
    button = 4'h0;
    slide  = 4'h0;
    ready  = 1'b0;

    // Single press of button 1 with slide 5, then release (one row per edge)
    for (int i = 0; i < 5; i++) tbl[i] = '{4'h2, 4'h5, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 6'h00};
    tbl[5]  = '{4'h2, 4'h5, 1'b0, 4'h2, 4'h5, 4'h2, 1'b0, 6'h00};
    tbl[6]  = '{4'h2, 4'h5, 1'b0, 4'h2, 4'h5, 4'h0, 1'b1, 6'h15};
    tbl[7]  = '{4'h2, 4'h5, 1'b0, 4'h2, 4'h5, 4'h0, 1'b1, 6'h15};
    tbl[8]  = '{4'h2, 4'h5, 1'b1, 4'h2, 4'h5, 4'h0, 1'b0, 6'h00};
    tbl[9]  = '{4'h2, 4'h5, 1'b1, 4'h2, 4'h5, 4'h0, 1'b0, 6'h00};
    for (int i = 10; i < 15; i++) tbl[i] = '{4'h0, 4'h5, 1'b0, 4'h2, 4'h5, 4'h0, 1'b0, 6'h00};
    tbl[15] = '{4'h0, 4'h5, 1'b0, 4'h0, 4'h5, 4'h0, 1'b0, 6'h00};

    exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2; exp_idx[3] = 3; exp_idx[4] = 0;

    // Reset with all buttons held
    reset = 1'b1; button = 4'hF; slide = 4'hA; ready = 1'b1;
    tick();
    chk("rst_outs0", {button_level, slide_level, press_pulse, event_valid, event_code, overflow}, 0);
    tick();
    chk("rst_outs1", {button_level, slide_level, press_pulse, event_valid, event_code, overflow}, 0);
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_lvl_e5", button_level, 4'h0);
    tick();
    chk("rst_lvl_e6", button_level, 4'hF);
    chk("rst_sl_e6", slide_level, 4'hA);
    chk("rst_pulse_e6", press_pulse, 4'hF);
    chk("rst_valid_e6", event_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_ev_valid", event_valid, 1'b1);
      chk("rst_ev_code", event_code, 32'(6'h28 + k));
    end
    tick();
    chk("rst_drained", event_valid, 1'b0);

    // Table-driven single press / release
    do_reset();
    for (int i = 0; i < 16; i++) begin
      button = tbl[i].b;
      slide  = tbl[i].s;
      ready  = tbl[i].r;
      tick();
      chk("tbl_blevel", button_level, tbl[i].bl);
      chk("tbl_slevel", slide_level, tbl[i].sl);
      chk("tbl_pulse", press_pulse, tbl[i].p);
      chk("tbl_valid", event_valid, tbl[i].v);
      chk("tbl_code", event_code, tbl[i].c);
    end

    // Glitch shorter than the debounce window
    do_reset();
    ready  = 1'b1;
    button = 4'h4;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) button = 4'h0;
      tick();
      chk("glitch", {button_level, press_pulse, event_valid}, 0);
    end

    // Release of button 3 produces no pulse or event
    do_reset();
    ready  = 1'b1;
    button = 4'h8;
    repeat (10) tick();
    chk("rel_pressed", button_level, 4'h8);
    button = 4'h0;
    repeat (5) tick();
    chk("rel_held", button_level, 4'h8);
    tick();
    chk("rel_level", button_level, 4'h0);
    chk("rel_pulse", press_pulse, 4'h0);
    chk("rel_valid", event_valid, 1'b0);
    repeat (3) tick();
    chk("rel_noevent", event_valid, 1'b0);

    // Backpressure, merged press, full push+pop drain
    do_reset();
    slide = 4'h3;
    for (int b = 0; b < 4; b++) begin
      button = 4'(1 << b);
      repeat (8) tick();
      button = 4'h0;
      repeat (6) tick();
    end
    chk("bp_valid", event_valid, 1'b1);
    chk("bp_head", event_code, 6'h0C);
    chk("bp_ovf0", overflow, 1'b0);
    button = 4'h1;
    repeat (8) tick();
    chk("bp_pending_noovf", overflow, 1'b0);
    button = 4'h0;
    repeat (6) tick();
    button = 4'h1;
    repeat (5) tick();
    chk("bp_ovf_before", overflow, 1'b0);
    tick();
    chk("bp_ovf_set", overflow, 1'b1);
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", event_valid, 1'b1);
      chk("drain_code", event_code, 32'(6'h0C + exp_idx[k]));
      tick();
      if (k == 0) begin
        chk("fullpp_valid", event_valid, 1'b1);
        chk("fullpp_head", event_code, 6'h0D);
      end
    end
    chk("drain_empty", event_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);

    // Random stimulus against the model
    do_reset();
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pct = int'($urandom_range(5, 95));
      if ($urandom_range(0, 11) == 0) begin
        bi = int'($urandom_range(0, 3));
        button[bi] = ~button[bi];
      end
      if ($urandom_range(0, 39) == 0) begin
        bi = int'($urandom_range(0, 3));
        slide[bi] = ~slide[bi];
      end
      ready = (int'($urandom_range(0, 99)) < pct);
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_scanner.md
# button_event_scanner

Input front-end for the LED controller: synchronizes and debounces the four raw push-buttons and four slide switches, and presents clean levels plus one-cycle press pulses. It also queues each button press, tagged with the slide-switch setting, in a 4-entry event FIFO. The FIFO is read through a valid/ready handshake by the LED control logic, which consumes events instead of sampling raw pins.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 1..2^CNT_W-1
- CNT_W, 19, debounce counter width
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- button  in  4  raw push-buttons, asynchronous, active-high
- slide  in  4  raw slide switches, asynchronous
- button_level  out  4  debounced button state
- slide_level  out  4  debounced slide state
- press_pulse  out  4  one-cycle pulse per accepted 0->1 of button_level
- event_valid  out  1  FIFO head holds an event
- event_code  out  6  [5:2] slide_level snapshot, [1:0] button index of head event
- event_ready  in  1  consumer accepts head this cycle
- overflow  out  1  sticky: a press was lost

## Operation
- Each of the 8 inputs has a 2-FF synchronizer (s1, s2), a CNT_W counter and a level register.
- Debounce per input:
  - s2 == level: counter cleared.
  - s2 != level: counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive edge with s2 != level, the level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES leaves the level unchanged.
- press_pulse[i] = button_level[i] & ~prev_level[i]. It is high for exactly the first cycle the level reads 1. Releases generate no pulse or event.
- Pending mask (4 bits): bit i is set on the edge where button_level[i] rises.
- Push logic, each edge:
  - If the pending mask is nonzero and the FIFO is not full, or a pop occurs on the same edge, push the lowest-index pending button and clear its bit.
  - event_code = {slide_level at push edge, index}.
  - At most one push per edge.
- Simultaneous presses are queued lowest index first, one per cycle.
- Press while the pending bit for that button is already set (FIFO backed up): the press is merged (no second event) and overflow is set.
- FIFO: 4 entries, first-word fall-through, 2-bit wrapping rd/wr pointers plus 3-bit count.
  - event_valid = (count != 0); event_code = head entry.
  - Pop on edge where event_valid && event_ready. event_ready while empty is ignored.
  - Full with pop and push on the same edge: both occur, count stays 4.
- Reset values:
  - All outputs 0: button_level, slide_level, press_pulse, event_valid, event_code, overflow.
  - Internal state: synchronizers, counters, pending mask, pointers and count all 0.
- Reset mid-operation discards queued events and pending presses.
- A button held through reset is re-debounced from level 0 and yields one press DEBOUNCE_CYCLES+2 edges after reset deasserts.

## Timing
- Edge numbering: raw input changes before edge 1 and stays stable.
  - s2 updates at edge 2.
  - Level changes at edge DEBOUNCE_CYCLES+2.
  - press_pulse is high in the cycle following that edge.
- Pending bit is set at the same edge as the level change. The event is pushed at edge DEBOUNCE_CYCLES+3, so event_valid is high after that edge.
- Consumer sees the head combinationally.
- Pop-to-next-head latency is one edge: the next entry is visible in the cycle after the pop edge.
- Slide changes affect only slide_level and later snapshots, never already-queued events.
- overflow rises on the edge the merged press is detected and holds until reset.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert reset 2 cycles with button=4'hF, slide=4'hA -> all outputs 0 while reset is high. After release, button_level=4'hF at edge 6, four events follow with indices 0,1,2,3 on consecutive cycles (event_ready=1), slide field 4'hA.
- Glitch reject: button[2] high for 3 cycles then low -> button_level stays 0, no press_pulse, event_valid stays 0.
- Single press: slide=4'h5, button[1] rises -> button_level[1]=1 at edge 6, press_pulse[1] one cycle, event_valid at edge 7 with event_code=6'b0101_01. Event pops on ready=1, then valid=0.
- Backpressure: event_ready=0, press buttons 0..3 one at a time, then press button 0 twice more -> FIFO holds 4 events. The first extra press sits pending; the second sets overflow=1. Raising ready drains 5 events: indices 0,1,2,3,0.
- Full push/pop: FIFO full, pending bit set, ready=1 -> a push and a pop occur on the same edge, count stays 4, order preserved.
- Release: button[3] falls after a press -> button_level[3]=0 at edge 6, no pulse, no event.
